softmax_seq_ctrl: RTL and testbench
===================================

// Module: softmax_seq_ctrl
// PURPOSE
//  Job-level sequencer for the softmax datapath of the attention head.
//  On a start pulse with a layer index it:
//   - presents the layer to the coefficient ROMs and waits for their data to settle;
//   - streams exactly N*N accumulator words from an upstream valid/ready source into softmax;
//   - limits rows in flight with a credit scheme;
//   - counts softmax outputs and pulses done, or flags a drain timeout.
// PARAMETERS
//  D_W_ACC        32    width of accumulator words fed to softmax
//  MATRIXSIZE_W   16    width of row/column counters
//  L              12    number of layers (ROM depth)
//  N              32    matrix dimension (row length and row count)
//  ROM_LAT        2     wait cycles after sm_layer update before the first beat is accepted
//  MAX_INFLIGHT   2     max rows started at input but not yet fully output
//  DRAIN_TIMEOUT  4096  max cycles in DRAIN between successive sm_out_valid beats
// PORTS
//  clk            in   1              clock
//  rst            in   1              synchronous active-high reset
//  start          in   1              job request pulse; sampled only in IDLE
//  start_layer    in   $clog2(L)      layer index for the job
//  busy           out  1              1 in every state except IDLE
//  done           out  1              one-cycle pulse on successful completion
//  src_valid      in   1              upstream word valid
//  src_data       in   D_W_ACC        upstream word, signed
//  src_ready      out  1              upstream handshake; beat transfers on src_valid & src_ready
//  sm_layer       out  $clog2(L)      layer index driven to the coefficient ROMs
//  sm_in_valid    out  1              softmax input valid, registered
//  sm_qin         out  D_W_ACC        softmax input word, registered
//  sm_out_valid   in   1              softmax output beat
//  out_row        out  MATRIXSIZE_W   row index of the next expected output beat
//  out_col        out  MATRIXSIZE_W   column index of the next expected output beat
//  err_timeout    out  1              sticky; DRAIN timed out
//  err_spurious   out  1              sticky; sm_out_valid seen in IDLE, LOAD or DONE
// BEHAVIOUR
//  Reset: every output above is 0; FSM returns to IDLE; all counters and credits clear.
//   A reset asserted mid-job aborts the job with no done pulse.
//  FSM transitions:
//   IDLE   : on start -> LOAD. sm_layer<=start_layer; both err flags clear; wait counter<=0.
//            A start outside IDLE is ignored.
//   LOAD   : src_ready=0. After ROM_LAT cycles -> STREAM.
//   STREAM : src_ready = (in_col!=0) | (inflight<MAX_INFLIGHT). Rows may not start without a credit.
//            Each beat: sm_qin<=src_data and sm_in_valid<=1 on the next cycle, else sm_in_valid<=0.
//            in_col wraps at N-1 and then in_row increments.
//            Beat at (N-1,N-1) -> DRAIN.
//   DRAIN  : src_ready=0. The timeout counter restarts on every sm_out_valid.
//            Last output beat (out_row=N-1, out_col=N-1) -> DONE.
//            Timeout reaching DRAIN_TIMEOUT -> err_timeout=1 and -> IDLE without done.
//   DONE   : done=1 for exactly one cycle -> IDLE. sm_layer holds its value.
//  Credits (inflight):
//   - +1 on the accepted beat with in_col==0.
//   - -1 on sm_out_valid with out_col==N-1.
//   - Both in the same cycle: inflight is unchanged.
//   - Range 0..MAX_INFLIGHT.
//  Output tracking: out_col/out_row advance on sm_out_valid in STREAM or DRAIN.
//   out_col wraps at N-1 and then out_row increments. Both reset to 0 on the IDLE->LOAD transition.
//  Output beats in STREAM are legal and counted; the last output beat can only occur in DRAIN.
//  sm_out_valid in IDLE, LOAD or DONE sets err_spurious and is not counted.
//  sm_layer holds its value for the whole job.
//  Counter and credit widths: MATRIXSIZE_W bits, and $clog2(MAX_INFLIGHT+1) bits for inflight.
// STRUCTURE
//  Shared package softmax_ctrl_pkg holds:
//   - the FSM state encoding (IDLE, LOAD, STREAM, DRAIN, DONE);
//   - localparam widths for the credit and timeout counters.
//  One sub-module, sm_credit_tracker: the inflight counter.
//   - inputs: row_start, row_end, clear;
//   - output: has_credit.
//  Everything else lives in the top-level FSM.
// TESTING  (bench: N=4, MAX_INFLIGHT=2, ROM_LAT=2, small DRAIN_TIMEOUT=16)
//  1 start with layer=5, src_valid held 1, softmax model of latency 6
//    -> sm_layer=5 and src_ready=0 for 2 cycles; 16 beats then done pulses once.
//  2 softmax model stalled for row outputs
//    -> src_ready drops at the in_col==0 of the third row and stays 0 until row 0's last output beat.
//  3 start pulsed during STREAM
//    -> ignored: sm_layer is unchanged and exactly 16 input beats are issued.
//  4 softmax model drops its final output beat
//    -> 16 idle cycles in DRAIN, then err_timeout=1, FSM returns to IDLE, no done pulse.
//  5 rst asserted after 7 input beats
//    -> next cycle all outputs are 0; a fresh start runs a complete 16-beat job.
//  6 sm_out_valid pulsed while IDLE
//    -> err_spurious=1; it clears on the next start.

Source files
------------

// File: rtl/softmax_ctrl_pkg.sv
// Shared definitions for the softmax job sequencer: FSM encoding, default
// sizing constants and the counter-width helper.
package softmax_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } sm_state_e;

    localparam int unsigned MAX_INFLIGHT_DEF  = 2;
    localparam int unsigned DRAIN_TIMEOUT_DEF = 4096;

    // Bits needed to hold any value in 0..max_val.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int unsigned CREDIT_W_DEF = cnt_w(MAX_INFLIGHT_DEF);
    localparam int unsigned TMO_W_DEF    = cnt_w(DRAIN_TIMEOUT_DEF);

endpackage

// File: rtl/sm_credit_tracker.sv
// Rows-in-flight counter: a row takes a credit when its first word enters
// softmax and returns it when its last output word leaves.
module sm_credit_tracker
    import softmax_ctrl_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic row_start,
    input  logic row_end,
    output logic has_credit
);

    localparam int unsigned         CREDIT_W = cnt_w(MAX_INFLIGHT);
    localparam logic [CREDIT_W-1:0] MAX_CNT  = CREDIT_W'(MAX_INFLIGHT);

    logic [CREDIT_W-1:0] inflight;
    logic [CREDIT_W-1:0] inflight_nxt;

    // Simultaneous start and end cancel out; the count saturates at both ends.
    always_comb begin
        inflight_nxt = inflight;
        if (row_start && !row_end && (inflight != MAX_CNT)) begin
            inflight_nxt = inflight + CREDIT_W'(1);
        end else if (row_end && !row_start && (inflight != '0)) begin
            inflight_nxt = inflight - CREDIT_W'(1);
        end
    end

    // has_credit is registered alongside the count so it always mirrors it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            inflight   <= '0;
            has_credit <= (MAX_INFLIGHT != 0);
        end else begin
            inflight   <= inflight_nxt;
            has_credit <= (inflight_nxt < MAX_CNT);
        end
    end

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Job-level sequencer for the attention-head softmax: ROM settle, credit-limited
// N*N word stream into softmax, output tracking, done pulse or drain timeout.
module softmax_seq_ctrl
    import softmax_ctrl_pkg::*;
#(
    parameter int unsigned D_W_ACC       = 32,
    parameter int unsigned MATRIXSIZE_W  = 16,
    parameter int unsigned L             = 12,
    parameter int unsigned N             = 32,
    parameter int unsigned ROM_LAT       = 2,
    parameter int unsigned MAX_INFLIGHT  = MAX_INFLIGHT_DEF,
    parameter int unsigned DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [$clog2(L)-1:0]    start_layer,
    output logic                    busy,
    output logic                    done,
    input  logic                    src_valid,
    input  logic [D_W_ACC-1:0]      src_data,
    output logic                    src_ready,
    output logic [$clog2(L)-1:0]    sm_layer,
    output logic                    sm_in_valid,
    output logic [D_W_ACC-1:0]      sm_qin,
    input  logic                    sm_out_valid,
    output logic [MATRIXSIZE_W-1:0] out_row,
    output logic [MATRIXSIZE_W-1:0] out_col,
    output logic                    err_timeout,
    output logic                    err_spurious
);

    localparam int unsigned             WAIT_W    = cnt_w(ROM_LAT);
    localparam int unsigned             TMO_W     = cnt_w(DRAIN_TIMEOUT);
    localparam logic [MATRIXSIZE_W-1:0] LAST_IDX  = MATRIXSIZE_W'(N - 1);
    localparam logic [WAIT_W-1:0]       LOAD_LAST = WAIT_W'((ROM_LAT > 1) ? ROM_LAT - 1 : 0);
    localparam logic [TMO_W-1:0]        TMO_LAST  = TMO_W'((DRAIN_TIMEOUT > 1) ? DRAIN_TIMEOUT - 1 : 0);

    sm_state_e               state;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [TMO_W-1:0]        tmo_cnt;
    logic [MATRIXSIZE_W-1:0] in_row;
    logic [MATRIXSIZE_W-1:0] in_col;
    logic                    has_credit;

    logic in_beat, row_start, out_live, out_beat, row_end;
    logic in_col_last, in_row_last, out_col_last, out_row_last;

    // A new row may only begin while a credit is free; mid-row beats always flow.
    assign src_ready    = (state == ST_STREAM) && ((in_col != '0) || has_credit);
    assign in_beat      = src_valid && src_ready;
    assign row_start    = in_beat && (in_col == '0);
    assign in_col_last  = (in_col == LAST_IDX);
    assign in_row_last  = (in_row == LAST_IDX);

    assign out_live     = (state == ST_STREAM) || (state == ST_DRAIN);
    assign out_beat     = sm_out_valid && out_live;
    assign out_col_last = (out_col == LAST_IDX);
    assign out_row_last = (out_row == LAST_IDX);
    assign row_end      = out_beat && out_col_last;

    sm_credit_tracker #(
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .clear      ((state == ST_IDLE) && start),
        .row_start  (row_start),
        .row_end    (row_end),
        .has_credit (has_credit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            sm_layer     <= '0;
            sm_in_valid  <= 1'b0;
            sm_qin       <= '0;
            out_row      <= '0;
            out_col      <= '0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
            wait_cnt     <= '0;
            tmo_cnt      <= '0;
            in_row       <= '0;
            in_col       <= '0;
        end else begin
            done        <= 1'b0;
            sm_in_valid <= in_beat;
            if (in_beat) begin
                sm_qin <= src_data;
                if (in_col_last) begin
                    in_col <= '0;
                    in_row <= in_row_last ? '0 : in_row + MATRIXSIZE_W'(1);
                end else begin
                    in_col <= in_col + MATRIXSIZE_W'(1);
                end
            end

            if (out_beat) begin
                if (out_col_last) begin
                    out_col <= '0;
                    out_row <= out_row_last ? '0 : out_row + MATRIXSIZE_W'(1);
                end else begin
                    out_col <= out_col + MATRIXSIZE_W'(1);
                end
            end

            if (sm_out_valid && !out_live) begin
                err_spurious <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_LOAD;
                        busy         <= 1'b1;
                        sm_layer     <= start_layer;
                        err_timeout  <= 1'b0;
                        err_spurious <= sm_out_valid;
                        wait_cnt     <= '0;
                        out_row      <= '0;
                        out_col      <= '0;
                        in_row       <= '0;
                        in_col       <= '0;
                    end
                end
                ST_LOAD: begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                    if (wait_cnt == LOAD_LAST) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (in_beat && in_col_last && in_row_last) begin
                        state   <= ST_DRAIN;
                        tmo_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    // Any output beat restarts the silence window.
                    if (out_beat && out_col_last && out_row_last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (sm_out_valid) begin
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Scoreboard bench for softmax_seq_ctrl with a small softmax latency model
// (N=4, MAX_INFLIGHT=2, ROM_LAT=2, DRAIN_TIMEOUT=16).
module tb_softmax_seq_ctrl;

    localparam int unsigned D_W_ACC       = 32;
    localparam int unsigned MATRIXSIZE_W  = 16;
    localparam int unsigned L             = 12;
    localparam int unsigned N             = 4;
    localparam int unsigned ROM_LAT       = 2;
    localparam int unsigned MAX_INFLIGHT  = 2;
    localparam int unsigned DRAIN_TIMEOUT = 16;
    localparam int unsigned LAYER_W       = $clog2(L);
    localparam int          BEATS         = N * N;
    localparam int          SM_LAT        = 6;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [LAYER_W-1:0]      start_layer;
    logic                    busy;
    logic                    done;
    logic                    src_valid;
    logic [D_W_ACC-1:0]      src_data;
    logic                    src_ready;
    logic [LAYER_W-1:0]      sm_layer;
    logic                    sm_in_valid;
    logic [D_W_ACC-1:0]      sm_qin;
    logic                    sm_out_valid;
    logic [MATRIXSIZE_W-1:0] out_row;
    logic [MATRIXSIZE_W-1:0] out_col;
    logic                    err_timeout;
    logic                    err_spurious;

    int checks = 0;
    int errors = 0;
    int in_beats = 0;
    int out_acc = 0;
    int done_cnt = 0;
    int edge_n = 0;
    int last_out_edge = 0;
    logic [D_W_ACC-1:0] exp_q[$];

    bit stall = 1'b0;
    bit drop_last = 1'b0;
    bit spur_req = 1'b0;
    int pend[$];
    int mt = 0;
    int pops = 0;

    softmax_seq_ctrl #(
        .D_W_ACC       (D_W_ACC),
        .MATRIXSIZE_W  (MATRIXSIZE_W),
        .L             (L),
        .N             (N),
        .ROM_LAT       (ROM_LAT),
        .MAX_INFLIGHT  (MAX_INFLIGHT),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_layer  (start_layer),
        .busy         (busy),
        .done         (done),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_ready    (src_ready),
        .sm_layer     (sm_layer),
        .sm_in_valid  (sm_in_valid),
        .sm_qin       (sm_qin),
        .sm_out_valid (sm_out_valid),
        .out_row      (out_row),
        .out_col      (out_col),
        .err_timeout  (err_timeout),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected softmax input word whenever the DUT presents one.
    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
        if (sm_in_valid) begin
            in_beats++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sm_qin_extra: actual beat 0x%0h required none", sm_qin);
            end else begin
                check("sm_qin", 64'(sm_qin), 64'(exp_q.pop_front()));
            end
        end
    end

    // Count output beats as the DUT samples them.
    initial forever begin
        @(posedge clk);
        if (sm_out_valid) begin
            out_acc++;
            last_out_edge = edge_n;
        end
        edge_n++;
    end

    // Softmax model: fixed latency, optional stall, optional loss of the final beat.
    initial begin
        sm_out_valid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            mt++;
            if (rst) begin
                pend.delete();
                pops = 0;
                sm_out_valid = 1'b0;
            end else begin
                if (sm_in_valid) pend.push_back(mt + SM_LAT);
                sm_out_valid = spur_req;
                if (!stall && pend.size() > 0 && pend[0] <= mt) begin
                    void'(pend.pop_front());
                    if (!(drop_last && (pops % BEATS) == BEATS - 1)) sm_out_valid = 1'b1;
                    pops++;
                end
            end
        end
    end

    task automatic start_job(input logic [LAYER_W-1:0] layer);
        start = 1'b1;
        start_layer = layer;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int n, input int base, input bit inject);
        int i = 0;
        int cyc = 0;
        src_valid = 1'b1;
        while (i < n && cyc < 200) begin
            src_data = 32'(base + i * 37 - 300);
            if (inject && i == 5) begin
                start = 1'b1;
                start_layer = LAYER_W'(9);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (src_ready) begin
                exp_q.push_back(src_data);
                i++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("feed_beats", 64'(i), 64'(n));
    endtask

    task automatic wait_idle(input string name, output int e);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (busy && cyc < 300);
        e = edge_n;
        check(name, 64'(busy), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctrl"}, 64'({busy, done, src_ready, sm_in_valid, err_timeout, err_spurious, sm_layer}), 64'(0));
        check({name, "_qin"}, 64'(sm_qin), 64'(0));
        check({name, "_idx"}, 64'({out_row, out_col}), 64'(0));
    endtask

    initial begin
        int ib0, oa0, dc0, e, hi, cyc;
        rst = 1'b1;
        start = 1'b0;
        start_layer = '0;
        src_valid = 1'b0;
        src_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic job: ROM settle window, 16 beats, one done pulse.
        ib0 = in_beats; oa0 = out_acc; dc0 = done_cnt;
        start_job(LAYER_W'(5));
        check("load_layer", 64'(sm_layer), 64'(5));
        check("load_busy", 64'(busy), 64'(1));
        check("load_ready_c0", 64'(src_ready), 64'(0));
        @(posedge clk); #1;
        check("load_ready_c1", 64'(src_ready), 64'(0));
        @(posedge clk); #1;
        check("stream_ready", 64'(src_ready), 64'(1));
        feed(BEATS, 0, 1'b0);
        wait_idle("job1_idle", e);
        src_valid = 1'b0;
        check("job1_done", 64'(done_cnt - dc0), 64'(1));
        check("job1_in", 64'(in_beats - ib0), 64'(BEATS));
        check("job1_out", 64'(out_acc - oa0), 64'(BEATS));
        check("job1_layer_hold", 64'(sm_layer), 64'(5));
        check("job1_no_tmo", 64'(err_timeout), 64'(0));

        // Start during STREAM must be ignored.
        ib0 = in_beats; dc0 = done_cnt;
        start_job(LAYER_W'(5));
        feed(BEATS, 2000, 1'b1);
        check("midstart_layer", 64'(sm_layer), 64'(5));
        wait_idle("midstart_idle", e);
        src_valid = 1'b0;
        check("midstart_in", 64'(in_beats - ib0), 64'(BEATS));
        check("midstart_done", 64'(done_cnt - dc0), 64'(1));

        // Stalled softmax: third row waits for row 0 to drain.
        ib0 = in_beats; dc0 = done_cnt;
        start_job(LAYER_W'(3));
        stall = 1'b1;
        feed(2 * N, 1000, 1'b0);
        src_valid = 1'b0;
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (src_ready) hi++;
        end
        check("stall_ready_low", 64'(hi), 64'(0));
        check("stall_in", 64'(in_beats - ib0), 64'(2 * N));
        @(posedge clk); #1;
        stall = 1'b0;
        oa0 = out_acc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!src_ready && cyc < 50);
        check("credit_ready", 64'(src_ready), 64'(1));
        check("credit_rows_out", 64'(out_acc - oa0), 64'(N));
        @(posedge clk); #1;
        feed(BEATS - 2 * N, 1000 + 2 * N * 37, 1'b0);
        src_valid = 1'b0;
        wait_idle("stall_idle", e);
        check("stall_done", 64'(done_cnt - dc0), 64'(1));

        // Lost final output: drain timeout, no done.
        oa0 = out_acc; dc0 = done_cnt;
        drop_last = 1'b1;
        start_job(LAYER_W'(7));
        feed(BEATS, 3000, 1'b0);
        src_valid = 1'b0;
        wait_idle("tmo_idle", e);
        drop_last = 1'b0;
        check("tmo_flag", 64'(err_timeout), 64'(1));
        check("tmo_no_done", 64'(done_cnt - dc0), 64'(0));
        check("tmo_out", 64'(out_acc - oa0), 64'(BEATS - 1));
        check("tmo_window", 64'(e - last_out_edge), 64'(DRAIN_TIMEOUT + 1));

        // Spurious output beat in IDLE, cleared by the next start.
        spur_req = 1'b1;
        @(posedge clk); #1;
        spur_req = 1'b0;
        @(negedge clk);
        check("spur_flag", 64'(err_spurious), 64'(1));
        check("spur_idle", 64'(busy), 64'(0));
        @(posedge clk); #1;
        dc0 = done_cnt;
        start_job(LAYER_W'(2));
        check("spur_clear", 64'(err_spurious), 64'(0));
        check("tmo_clear", 64'(err_timeout), 64'(0));
        feed(BEATS, 5000, 1'b0);
        src_valid = 1'b0;
        wait_idle("spur_job_idle", e);
        check("spur_job_done", 64'(done_cnt - dc0), 64'(1));

        // Reset mid-job, then a clean job.
        dc0 = done_cnt;
        start_job(LAYER_W'(4));
        feed(7, 4000, 1'b0);
        src_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_q_empty", 64'(exp_q.size()), 64'(0));
        check("midrst_no_done", 64'(done_cnt - dc0), 64'(0));
        ib0 = in_beats;
        start_job(LAYER_W'(6));
        feed(BEATS, 6000, 1'b0);
        src_valid = 1'b0;
        wait_idle("postrst_idle", e);
        check("postrst_done", 64'(done_cnt - dc0), 64'(1));
        check("postrst_in", 64'(in_beats - ib0), 64'(BEATS));
        check("postrst_layer", 64'(sm_layer), 64'(6));

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
